// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash read responder (03h) serving bytes from an internal host-loaded memory.
// Optional build macro SPI_RESP_FAST_READ_EN adds 0Bh fast read with 8 dummy clocks.
module spi_flash_responder #(
    parameter int ADDR_BITS = 11
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 spi_cs,
    input  logic                 spi_sclk,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    input  logic                 mem_we,
    input  logic [ADDR_BITS-1:0] mem_waddr,
    input  logic [7:0]           mem_wdata,
    output logic                 busy,
    output logic                 cmd_err
);
    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [7:0] CMD_READ = 8'h03;
`ifdef SPI_RESP_FAST_READ_EN
    localparam logic [7:0] CMD_FAST_READ = 8'h0B;
`endif

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, IGNORE} state_e;

    logic [7:0] mem_q [DEPTH];

    state_e               state_q, state_d;
    logic                 cs_meta_q, cs_sync_q;
    logic                 sclk_meta_q, sclk_sync_q, sclk_prev_q;
    logic                 mosi_meta_q, mosi_sync_q;
    logic [1:0]           vld_q;
    logic                 armed_q, armed_d;
    logic [4:0]           cnt_q, cnt_d;
    logic [7:0]           cmd_q, cmd_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [7:0]           sreg_q, sreg_d;
    logic                 load_q, load_d;
    logic                 miso_q, miso_d;
    logic                 busy_q, busy_d;
    logic                 cmd_err_q, cmd_err_d;

    logic                 sclk_rise, sclk_fall;
    logic [7:0]           cmd_next;
    logic                 cmd_ok;
    logic                 fast_sel;
    logic [ADDR_BITS-1:0] addr_inc;

    assign sclk_rise = sclk_sync_q & ~sclk_prev_q;
    assign sclk_fall = ~sclk_sync_q & sclk_prev_q;
    assign cmd_next  = {cmd_q[6:0], mosi_sync_q};
    assign addr_inc  = addr_q + ADDR_BITS'(1);

`ifdef SPI_RESP_FAST_READ_EN
    assign cmd_ok   = (cmd_next == CMD_READ) || (cmd_next == CMD_FAST_READ);
    assign fast_sel = (cmd_q == CMD_FAST_READ);
`else
    assign cmd_ok   = (cmd_next == CMD_READ);
    assign fast_sel = 1'b0;
`endif

    // NOTE: the memory array has no reset; contents survive reset_n and it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= mem_wdata;
        end
    end

    always_comb begin
        // NOTE: every _d takes a default first so no path through the case infers a latch.
        state_d   = state_q;
        armed_d   = armed_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        addr_d    = addr_q;
        sreg_d    = sreg_q;
        load_d    = 1'b0;
        miso_d    = 1'b0;
        cmd_err_d = 1'b0;

        // A CS low seen only once the synchroniser holds real samples arms the block after reset.
        if (vld_q[1] && !cs_sync_q) begin
            armed_d = 1'b1;
        end

        if (!cs_sync_q) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (armed_q) begin
                        state_d = CMD;
                        cnt_d   = '0;
                    end
                end
                CMD: begin
                    if (sclk_rise) begin
                        cmd_d = cmd_next;
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d = '0;
                            if (cmd_ok) begin
                                state_d = ADDR;
                            end else begin
                                state_d   = IGNORE;
                                cmd_err_d = 1'b1;
                            end
                        end
                    end
                end
                ADDR: begin
                    if (sclk_rise) begin
                        addr_d = {addr_q[ADDR_BITS-2:0], mosi_sync_q};
                        cnt_d  = cnt_q + 5'd1;
                        if (cnt_q == 5'd23) begin
                            cnt_d = '0;
                            if (fast_sel) begin
                                state_d = DUMMY;
                            end else begin
                                state_d = DATA;
                                load_d  = 1'b1;
                            end
                        end
                    end
                end
                DUMMY: begin
                    if (sclk_rise) begin
                        cnt_d = cnt_q + 5'd1;
                        if (cnt_q == 5'd7) begin
                            cnt_d   = '0;
                            state_d = DATA;
                            load_d  = 1'b1;
                        end
                    end
                end
                DATA: begin
                    // cnt counts bits the initiator has sampled; the first fall after a load only presents the MSB.
                    if (load_q) begin
                        sreg_d = mem_q[addr_q];
                        cnt_d  = '0;
                    end else if (sclk_rise && cnt_q != 5'd8) begin
                        cnt_d = cnt_q + 5'd1;
                    end else if (sclk_fall && cnt_q != 5'd0) begin
                        if (cnt_q == 5'd8) begin
                            addr_d = addr_inc;
                            sreg_d = mem_q[addr_inc];
                            cnt_d  = '0;
                        end else begin
                            sreg_d = {sreg_q[6:0], 1'b0};
                        end
                    end
                    miso_d = sreg_d[7];
                end
                IGNORE: begin
                    state_d = IGNORE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values; a same-address
    // host write on the load edge therefore leaves the old byte in the shift register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cs_meta_q   <= 1'b0;
            cs_sync_q   <= 1'b0;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            mosi_meta_q <= 1'b0;
            mosi_sync_q <= 1'b0;
            vld_q       <= '0;
            armed_q     <= 1'b0;
            state_q     <= IDLE;
            cnt_q       <= '0;
            cmd_q       <= '0;
            addr_q      <= '0;
            sreg_q      <= '0;
            load_q      <= 1'b0;
            miso_q      <= 1'b0;
            busy_q      <= 1'b0;
            cmd_err_q   <= 1'b0;
        end else begin
            cs_meta_q   <= spi_cs;
            cs_sync_q   <= cs_meta_q;
            sclk_meta_q <= spi_sclk;
            sclk_sync_q <= sclk_meta_q;
            sclk_prev_q <= sclk_sync_q;
            mosi_meta_q <= spi_mosi;
            mosi_sync_q <= mosi_meta_q;
            vld_q       <= {vld_q[0], 1'b1};
            armed_q     <= armed_d;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            sreg_q      <= sreg_d;
            load_q      <= load_d;
            miso_q      <= miso_d;
            busy_q      <= busy_d;
            cmd_err_q   <= cmd_err_d;
        end
    end

    assign spi_miso = miso_q;
    assign busy     = busy_q;
    assign cmd_err  = cmd_err_q;

endmodule

// File: tb/tb_spi_flash_responder.sv
// Self-checking bench for spi_flash_responder: an SPI initiator model with a byte scoreboard.
module tb_spi_flash_responder;
    localparam int AB = 11;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          spi_cs = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_mosi = 1'b0;
    logic          spi_miso;
    logic          mem_we = 1'b0;
    logic [AB-1:0] mem_waddr = '0;
    logic [7:0]    mem_wdata = '0;
    logic          busy;
    logic          cmd_err;

    int total = 0;
    int bad = 0;
    int err_cycles = 0;

    logic [7:0] model [2**AB];
    logic [7:0] exp_q [$];

    spi_flash_responder #(.ADDR_BITS(AB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .spi_cs    (spi_cs),
        .spi_sclk  (spi_sclk),
        .spi_mosi  (spi_mosi),
        .spi_miso  (spi_miso),
        .mem_we    (mem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .busy      (busy),
        .cmd_err   (cmd_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (cmd_err === 1'b1) err_cycles++;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic host_write(input logic [AB-1:0] a, input logic [7:0] d);
        @(negedge clk);
        mem_we    = 1'b1;
        mem_waddr = a;
        mem_wdata = d;
        model[a]  = d;
        @(negedge clk);
        mem_we    = 1'b0;
    endtask

    // One SCLK period: MOSI set while SCLK low, MISO captured just before the rising edge.
    task automatic spi_bit(input logic b, output logic r);
        spi_mosi = b;
        wait_clk(5);
        r = spi_miso;
        spi_sclk = 1'b1;
        wait_clk(5);
        spi_sclk = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
        logic r;
        for (int i = 7; i >= 0; i--) begin
            spi_bit(tx[i], r);
            rx[i] = r;
        end
    endtask

    task automatic cs_start();
        @(negedge clk);
        spi_cs = 1'b1;
        wait_clk(4);
    endtask

    task automatic cs_end();
        spi_cs = 1'b0;
        wait_clk(6);
    endtask

    task automatic send_hdr(input logic [7:0] c, input logic [23:0] a);
        logic [7:0] rx;
        logic [7:0] acc;
        acc = '0;
        spi_byte(c, rx);
        acc = acc | rx;
        for (int i = 2; i >= 0; i--) begin
            spi_byte(a[i*8 +: 8], rx);
            acc = acc | rx;
        end
        total++;
        if (acc !== 8'h00) begin
            bad++;
            $display("FAIL hdr_miso: got %h want 00", acc);
        end
    endtask

    task automatic recv_bytes(input int n, input string name);
        logic [7:0] rx;
        logic [7:0] exp;
        for (int i = 0; i < n; i++) begin
            spi_byte(8'h00, rx);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL %s[%0d]: got %h with no expected byte queued", name, i, rx);
            end else begin
                exp = exp_q.pop_front();
                if (rx !== exp) begin
                    bad++;
                    $display("FAIL %s[%0d]: got %h want %h", name, i, rx, exp);
                end
            end
        end
    endtask

    task automatic test_reset();
        wait_clk(3);
        total++;
        if (spi_miso !== 1'b0) begin bad++; $display("FAIL rst_miso: got %b want 0", spi_miso); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++;
        if (cmd_err !== 1'b0) begin bad++; $display("FAIL rst_cmd_err: got %b want 0", cmd_err); end
        reset_n = 1'b1;
        wait_clk(4);
    endtask

    task automatic test_seq_read();
        for (int i = 0; i < 16; i++) host_write(AB'(16 + i), 8'(i));
        cs_start();
        send_hdr(8'h03, 24'h000010);
        for (int i = 0; i < 16; i++) exp_q.push_back(model[16 + i]);
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL seq_busy: got %b want 1", busy); end
        recv_bytes(16, "seq");
        cs_end();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL seq_idle: got %b want 0", busy); end
    endtask

    task automatic test_wrap();
        host_write(11'h7FF, 8'hA5);
        host_write(11'h000, 8'h3C);
        cs_start();
        send_hdr(8'h03, 24'h0007FF);
        exp_q.push_back(model[11'h7FF]);
        exp_q.push_back(model[11'h000]);
        recv_bytes(2, "wrap");
        cs_end();
    endtask

    task automatic test_bad_cmd(input logic [7:0] c, input string name);
        logic [7:0] rx;
        int base;
        base = err_cycles;
        cs_start();
        spi_byte(c, rx);
        total++;
        if (rx !== 8'h00) begin bad++; $display("FAIL %s_cmd_miso: got %h want 00", name, rx); end
        for (int i = 0; i < 4; i++) exp_q.push_back(8'h00);
        recv_bytes(4, name);
        total++;
        if (err_cycles - base !== 1) begin
            bad++;
            $display("FAIL %s_err_pulse: got %0d cycles want 1", name, err_cycles - base);
        end
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL %s_busy: got %b want 1", name, busy); end
        cs_end();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s_idle: got %b want 0", name, busy); end
    endtask

    task automatic test_fast_read();
`ifdef SPI_RESP_FAST_READ_EN
        int base;
        base = err_cycles;
        cs_start();
        send_hdr(8'h0B, 24'h000010);
        exp_q.push_back(8'h00);
        exp_q.push_back(model[16]);
        exp_q.push_back(model[17]);
        recv_bytes(3, "fast");
        cs_end();
        total++;
        if (err_cycles != base) begin bad++; $display("FAIL fast_err: got %0d pulses want 0", err_cycles - base); end
`else
        test_bad_cmd(8'h0B, "fast_off");
`endif
    endtask

    task automatic test_abort();
        logic r;
        logic [7:0] rx;
        host_write(11'h020, 8'h5A);
        host_write(11'h021, 8'hC3);
        cs_start();
        spi_byte(8'h03, rx);
        for (int i = 0; i < 12; i++) spi_bit(1'b1, r);
        cs_end();
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy: got %b want 0", busy); end
        total++;
        if (spi_miso !== 1'b0) begin bad++; $display("FAIL abort_miso: got %b want 0", spi_miso); end
        cs_start();
        send_hdr(8'h03, 24'h000020);
        exp_q.push_back(model[11'h020]);
        exp_q.push_back(model[11'h021]);
        recv_bytes(2, "abort_rd");
        cs_end();
    endtask

    task automatic test_write_during();
        host_write(11'h030, 8'h11);
        host_write(11'h031, 8'h22);
        cs_start();
        send_hdr(8'h03, 24'h000030);
        // Byte 0 is already in the shift register; byte 1 is fetched after the writes.
        exp_q.push_back(model[11'h030]);
        host_write(11'h030, 8'hEE);
        host_write(11'h031, 8'h77);
        exp_q.push_back(model[11'h031]);
        recv_bytes(2, "wr_during");
        cs_end();
    endtask

    task automatic test_reset_mid();
        logic r;
        logic [7:0] rx;
        host_write(11'h040, 8'hFF);
        cs_start();
        send_hdr(8'h03, 24'h000040);
        for (int i = 0; i < 3; i++) spi_bit(1'b0, r);
        total++;
        if (r !== model[11'h040][5]) begin bad++; $display("FAIL mid_pre_bit: got %b want 1", r); end
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        total++;
        if (spi_miso !== 1'b0) begin bad++; $display("FAIL mid_rst_miso: got %b want 0", spi_miso); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
        wait_clk(2);
        reset_n = 1'b1;
        wait_clk(2);
        // CS is still high: the block must stay idle and ignore SCLK.
        spi_byte(8'h03, rx);
        spi_byte(8'h00, rx);
        total++;
        if (rx !== 8'h00) begin bad++; $display("FAIL mid_ignore_miso: got %h want 00", rx); end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL mid_ignore_busy: got %b want 0", busy); end
        cs_end();
        cs_start();
        send_hdr(8'h03, 24'h000040);
        exp_q.push_back(model[11'h040]);
        recv_bytes(1, "mid_rd");
        cs_end();
    endtask

    initial begin
        for (int i = 0; i < 2**AB; i++) model[i] = 8'h00;
        test_reset();
        test_seq_read();
        test_wrap();
        test_bad_cmd(8'h9F, "bad9f");
        test_fast_read();
        test_abort();
        test_write_during();
        test_reset_mid();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL sb_leftover: got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/spi_flash_responder.md
SPI_FLASH_RESPONDER -- requirements
Module: spi_flash_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 11, meaning byte-address width of internal memory (depth 2^ADDR_BITS bytes).
REQ-002 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port spi_cs  input  1  chip select, active HIGH.
REQ-005 SHALL have port spi_sclk  input  1  SPI clock, mode 0, asynchronous to clk.
REQ-006 SHALL have port spi_mosi  input  1  command/address bits from initiator, MSB first.
REQ-007 SHALL have port spi_miso  output  1  data bits to initiator, MSB first.
REQ-008 SHALL have port mem_we  input  1  host write strobe for internal memory.
REQ-009 SHALL have port mem_waddr  input  ADDR_BITS  host write address.
REQ-010 SHALL have port mem_wdata  input  8  host write data.
REQ-011 SHALL have port busy  output  1  high while a transaction is in progress (state not IDLE).
REQ-012 SHALL have port cmd_err  output  1  one-clk pulse when an unsupported command byte completes.

Function
REQ-013 SHALL pass spi_cs, spi_sclk and spi_mosi each through a 2-flop synchroniser before use; SCLK high and low phases SHALL each be at least 4 clk periods.
REQ-014 SHALL detect SCLK rising/falling edges from the synchronised SCLK; a MOSI bit SHALL be sampled on each SCLK rising edge.
REQ-015 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, IGNORE.
REQ-016 IDLE -> CMD when synchronised CS goes high; bit counter cleared.
REQ-017 CMD: after 8 sampled bits, command 03h -> ADDR; any other value -> IGNORE with cmd_err pulsed for 1 clk.
REQ-018 ADDR: sample 24 address bits; bits [ADDR_BITS-1:0] kept, upper bits discarded; after 24th bit -> DATA.
REQ-019 DATA: on entry, load shift register with mem[addr] and drive its MSB on spi_miso; on each subsequent SCLK falling edge shift out the next bit.
REQ-020 After 8 bits of a byte, the next falling edge SHALL present MSB of mem[addr+1]; addr SHALL wrap modulo 2^ADDR_BITS.
REQ-021 spi_miso SHALL update no later than 3 clk after the synchronised SCLK falling edge that triggers it, and hold stable through the next SCLK rising edge.
REQ-022 IGNORE: spi_miso held 0; remain until CS deasserts.
REQ-023 CS deassertion in any state SHALL return to IDLE within 3 clk, drive spi_miso 0, discard partial command/address; memory unaffected.
REQ-024 spi_miso SHALL be 0 in IDLE, CMD, ADDR, DUMMY, IGNORE; never tri-stated.
REQ-025 mem_we SHALL write mem_wdata to mem[mem_waddr] on the same clk edge regardless of SPI state; a byte already loaded into the shift register SHALL NOT change; a simultaneous write and shift-register load of the same address SHALL load the old value.
REQ-026 Memory contents SHALL be unaffected by reset.

Reset
REQ-027 On reset_n low, asynchronously: state IDLE, spi_miso 0, busy 0, cmd_err 0, bit counter 0, address 0, shift register 0, synchronisers 0.
REQ-028 Reset asserted mid-transaction SHALL abort it; after release, the block SHALL wait for CS low then high before accepting a new command.

Configuration
REQ-029 Macro SPI_RESP_FAST_READ_EN: when defined, command 0Bh SHALL be accepted: ADDR -> DUMMY for 8 SCLK cycles (spi_miso 0) -> DATA as for 03h.
REQ-030 Without SPI_RESP_FAST_READ_EN, 0Bh SHALL be treated as unsupported (IGNORE, cmd_err pulse).

Verification
REQ-031 Host writes mem[0x010..0x01F]=0x00..0x0F; SPI 03h, addr 0x000010, 128 SCLKs -> spi_miso yields bytes 0x00..0x0F MSB first.
REQ-032 mem[0x7FF]=0xA5, mem[0x000]=0x3C; 03h addr 0x0007FF, 16 SCLKs -> 0xA5 then 0x3C (wrap).
REQ-033 Command 9Fh -> cmd_err one pulse, spi_miso 0 for 32 further SCLKs, busy high until CS low.
REQ-034 CS dropped after 12 address bits, then fresh 03h addr 0x000020 -> first byte equals mem[0x020]; no residue from aborted transfer.
REQ-035 reset_n pulsed low mid-DATA -> spi_miso 0 and busy 0 immediately; block ignores SCLK until a new CS low-high cycle.
REQ-036 With SPI_RESP_FAST_READ_EN: 0Bh addr 0x000010 -> 8 zero dummy bits then 0x00, 0x01; without it -> cmd_err pulse.
